// File: rtl/scb_issue_arbiter_pkg.sv
// scb_issue_arbiter_pkg: scb_defs package of codes and widths shared between the issue arbiter and the pip3 scoreboard
package scb_defs;
  localparam int W_PA_REG     = 5;
  localparam int W_PD_UOPS    = 6;
  localparam int W_PC_SEL_RSV = 2;
  localparam int W_PC_SEL_ODR = 2;
  localparam int MAX_RETRY    = 4;
  localparam int W_RETRY      = 3;
  typedef logic [W_PD_UOPS-1:0]    uops_t;
  typedef logic [W_PA_REG-1:0]     rd_t;
  typedef logic [W_PC_SEL_RSV-1:0] selrsv_t;
  typedef logic [W_PC_SEL_ODR-1:0] odr_t;
  localparam uops_t   unused_op = '1;
  localparam selrsv_t V_unpip   = 2'b00;
  localparam selrsv_t V_pip0    = 2'b01;
  localparam selrsv_t V_pip1    = 2'b10;
  localparam odr_t    V_odrnone = 2'b00;
  localparam odr_t    V_odrf0   = 2'b01;
  localparam odr_t    V_odrf1   = 2'b10;
endpackage

// File: rtl/scb_issue_arbiter_if.sv
// scb_issue_arbiter_if: issue-queue and scoreboard signals around the arbiter; slave is the arbiter side
interface scb_issue_arbiter_if;
  import scb_defs::*;
  logic    RS0_valid;
  uops_t   RS0_uops;
  rd_t     RS0_rd;
  logic    RS0_ready;
  logic    RS1_valid;
  uops_t   RS1_uops;
  rd_t     RS1_rd;
  logic    RS1_ready;
  uops_t   CDI_PD_uops0;
  uops_t   CDI_PD_uops1;
  rd_t     CDI_PD_rd0;
  rd_t     CDI_PD_rd1;
  odr_t    CDI_PC_odr;
  selrsv_t CDO_PC_selrsv;
  logic    CFI_PC_clear;
  modport master (
    output RS0_valid, RS0_uops, RS0_rd, RS1_valid, RS1_uops, RS1_rd, CDO_PC_selrsv, CFI_PC_clear,
    input  RS0_ready, RS1_ready, CDI_PD_uops0, CDI_PD_uops1, CDI_PD_rd0, CDI_PD_rd1, CDI_PC_odr
  );
  modport slave (
    input  RS0_valid, RS0_uops, RS0_rd, RS1_valid, RS1_uops, RS1_rd, CDO_PC_selrsv, CFI_PC_clear,
    output RS0_ready, RS1_ready, CDI_PD_uops0, CDI_PD_uops1, CDI_PD_rd0, CDI_PD_rd1, CDI_PC_odr
  );
endinterface

// File: rtl/scb_issue_arbiter_slot.sv
// scb_issue_slot: one-entry holding register; outputs are registered and read as a bubble when empty
module scb_issue_slot
  import scb_defs::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_clr,
  input  logic  i_load,
  input  logic  i_drain,
  input  uops_t i_uops,
  input  rd_t   i_rd,
  output logic  o_v,
  output uops_t o_uops,
  output rd_t   o_rd
);
  logic  r_v;
  uops_t r_uops;
  rd_t   r_rd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_clr || (i_drain && !i_load)) begin
      r_v    <= 1'b0;
      r_uops <= unused_op;
      r_rd   <= '0;
    end else if (i_load) begin
      r_v    <= 1'b1;
      r_uops <= i_uops;
      r_rd   <= i_rd;
    end
  end
  assign o_v    = r_v;
  assign o_uops = r_uops;
  assign o_rd   = r_rd;
endmodule

// File: rtl/scb_issue_arbiter.sv
// scb_issue_arbiter: round-robin + retry-timeout arbiter offering one of two issue slots to the scoreboard.
// Optional SCB_ARB_PERF_EN adds saturating 16-bit accept/stall counters.
module scb_issue_arbiter
  import scb_defs::*;
(
  input logic clk,
  input logic rst,
  scb_issue_arbiter_if.slave bus
`ifdef SCB_ARB_PERF_EN
  ,
  output logic [15:0] PERF_acc0,
  output logic [15:0] PERF_acc1,
  output logic [15:0] PERF_stall
`endif
);
  logic [1:0]         w_v;
  logic               w_acc0, w_acc1, w_rdy0, w_rdy1, w_load0, w_load1;
  logic               w_refused, w_last;
  odr_t               w_odr;
  logic               r_ptr;
  logic [W_RETRY-1:0] r_retry;
  assign w_acc0  = (bus.CDO_PC_selrsv == V_pip0) && w_v[0];
  assign w_acc1  = (bus.CDO_PC_selrsv == V_pip1) && w_v[1];
  // ready also drops while rst is held so the queues see no handshake during reset
  assign w_rdy0  = !rst && !bus.CFI_PC_clear && (!w_v[0] || w_acc0);
  assign w_rdy1  = !rst && !bus.CFI_PC_clear && (!w_v[1] || w_acc1);
  assign w_load0 = bus.RS0_valid && w_rdy0;
  assign w_load1 = bus.RS1_valid && w_rdy1;
  assign bus.RS0_ready = w_rdy0;
  assign bus.RS1_ready = w_rdy1;
  assign bus.CDI_PC_odr = w_odr;
  always_comb begin
    w_odr = (w_v == 2'b00) ? V_odrnone :
            (w_v == 2'b01) ? V_odrf0 :
            (w_v == 2'b10) ? V_odrf1 :
            r_ptr ? V_odrf1 : V_odrf0;
  end
  assign w_refused = (w_odr != V_odrnone) && !w_acc0 && !w_acc1;
  assign w_last    = r_retry == W_RETRY'(MAX_RETRY - 1);
  scb_issue_slot u_slot0 (
    .clk(clk), .rst(rst), .i_clr(bus.CFI_PC_clear), .i_load(w_load0), .i_drain(w_acc0),
    .i_uops(bus.RS0_uops), .i_rd(bus.RS0_rd), .o_v(w_v[0]), .o_uops(bus.CDI_PD_uops0), .o_rd(bus.CDI_PD_rd0)
  );
  scb_issue_slot u_slot1 (
    .clk(clk), .rst(rst), .i_clr(bus.CFI_PC_clear), .i_load(w_load1), .i_drain(w_acc1),
    .i_uops(bus.RS1_uops), .i_rd(bus.RS1_rd), .o_v(w_v[1]), .o_uops(bus.CDI_PD_uops1), .o_rd(bus.CDI_PD_rd1)
  );
  // a refused lone slot only saturates the counter; switching needs the other slot to be waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.CFI_PC_clear) begin
      r_ptr   <= 1'b0;
      r_retry <= '0;
    end else if (w_acc0 || w_acc1) begin
      r_ptr   <= w_acc0;
      r_retry <= '0;
    end else if (w_refused) begin
      if (&w_v && w_last) begin
        r_ptr   <= !r_ptr;
        r_retry <= '0;
      end else if (!w_last) begin
        r_retry <= r_retry + W_RETRY'(1);
      end
    end else begin
      r_retry <= '0;
    end
  end
`ifdef SCB_ARB_PERF_EN
  logic [15:0] r_pacc0, r_pacc1, r_pstall;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pacc0  <= '0;
      r_pacc1  <= '0;
      r_pstall <= '0;
    end else begin
      if (w_acc0 && !(&r_pacc0)) r_pacc0 <= r_pacc0 + 16'd1;
      if (w_acc1 && !(&r_pacc1)) r_pacc1 <= r_pacc1 + 16'd1;
      if (w_refused && !(&r_pstall)) r_pstall <= r_pstall + 16'd1;
    end
  end
  assign PERF_acc0  = r_pacc0;
  assign PERF_acc1  = r_pacc1;
  assign PERF_stall = r_pstall;
`endif
endmodule

// File: tb/tb_scb_issue_arbiter.sv
// tb_scb_issue_arbiter: directed scenarios plus a randomized run against a behavioural model of the arbiter
module tb_scb_issue_arbiter;
  import scb_defs::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  scb_issue_arbiter_if bus();
  int errors = 0;
  int checks = 0;
`ifdef SCB_ARB_PERF_EN
  logic [15:0] perf_acc0, perf_acc1, perf_stall;
`endif
  scb_issue_arbiter dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef SCB_ARB_PERF_EN
    , .PERF_acc0(perf_acc0), .PERF_acc1(perf_acc1), .PERF_stall(perf_stall)
`endif
  );
  task automatic drive(input logic v0, input uops_t u0, input rd_t r0, input logic v1, input uops_t u1,
                       input rd_t r1, input selrsv_t sel, input logic clr);
    bus.RS0_valid = v0; bus.RS0_uops = u0; bus.RS0_rd = r0;
    bus.RS1_valid = v1; bus.RS1_uops = u1; bus.RS1_rd = r1;
    bus.CDO_PC_selrsv = sel; bus.CFI_PC_clear = clr;
  endtask
  task automatic idle(input selrsv_t sel);
    drive(1'b0, 6'h0, 5'd0, 1'b0, 6'h0, 5'd0, sel, 1'b0);
  endtask
  task automatic do_reset();
    idle(V_unpip);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    drive(1'b1, 6'h11, 5'd1, 1'b1, 6'h12, 5'd2, V_unpip, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.CDI_PC_odr, bus.CDI_PD_uops0, bus.CDI_PD_uops1, bus.CDI_PD_rd0, bus.CDI_PD_rd1, bus.RS0_ready, bus.RS1_ready}
        !== {V_odrnone, 6'h3F, 6'h3F, 5'd0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: odr=%b u0=%h u1=%h rd0=%0d rd1=%0d rdy=%b%b, want odr=00 u0=3f u1=3f rd=0 rdy=00",
               bus.CDI_PC_odr, bus.CDI_PD_uops0, bus.CDI_PD_uops1, bus.CDI_PD_rd0, bus.CDI_PD_rd1, bus.RS0_ready, bus.RS1_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 6'h05, 5'd3, 1'b0, 6'h0, 5'd0, V_unpip, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if ({bus.CDI_PC_odr, bus.CDI_PD_uops0, bus.CDI_PD_rd0} !== {V_odrf0, 6'h05, 5'd3}) begin
      errors++;
      $display("FAIL reset_first_offer: odr=%b u0=%h rd0=%0d, want odr=01 u0=05 rd0=3",
               bus.CDI_PC_odr, bus.CDI_PD_uops0, bus.CDI_PD_rd0);
    end
  endtask
  task automatic test_alternation();
    int k0, k1;
    odr_t e;
    do_reset();
    drive(1'b1, 6'h10, 5'd1, 1'b1, 6'h20, 5'd2, V_unpip, 1'b0);
    #1;
    checks++;
    if ({bus.CDI_PC_odr, bus.RS0_ready, bus.RS1_ready} !== {V_odrnone, 2'b11}) begin
      errors++;
      $display("FAIL alt_empty: odr=%b rdy=%b%b, want 00 11", bus.CDI_PC_odr, bus.RS0_ready, bus.RS1_ready);
    end
    @(negedge clk);
    k0 = 1; k1 = 1;
    for (int i = 0; i < 8; i++) begin
      e = (i % 2 == 0) ? V_odrf0 : V_odrf1;
      drive(1'b1, 6'h10 + 6'(k0), 5'd1, 1'b1, 6'h20 + 6'(k1), 5'd2, (i % 2 == 0) ? V_pip0 : V_pip1, 1'b0);
      #1;
      checks++;
      if ({bus.CDI_PC_odr, bus.RS0_ready, bus.RS1_ready} !== {e, i % 2 == 0, i % 2 == 1}) begin
        errors++;
        $display("FAIL alt_offer[%0d]: odr=%b rdy=%b%b, want %b %b%b", i, bus.CDI_PC_odr,
                 bus.RS0_ready, bus.RS1_ready, e, i % 2 == 0, i % 2 == 1);
      end
      checks++;
      if ((i % 2 == 0 ? bus.CDI_PD_uops0 : bus.CDI_PD_uops1) !== (i % 2 == 0 ? 6'h10 + 6'(k0 - 1) : 6'h20 + 6'(k1 - 1))) begin
        errors++;
        $display("FAIL alt_uop[%0d]: u0=%h u1=%h k0=%0d k1=%0d", i, bus.CDI_PD_uops0, bus.CDI_PD_uops1, k0, k1);
      end
      @(negedge clk);
      if (i % 2 == 0) k0++; else k1++;
    end
  endtask
  task automatic test_hazard_timeout();
    do_reset();
    drive(1'b1, 6'h21, 5'd4, 1'b1, 6'h22, 5'd5, V_unpip, 1'b0);
    @(negedge clk);
    idle(V_unpip);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (bus.CDI_PC_odr !== V_odrf0) begin
        errors++;
        $display("FAIL hazard_hold[%0d]: odr=%b want 01", c, bus.CDI_PC_odr);
      end
      @(negedge clk);
    end
    bus.CDO_PC_selrsv = V_pip1;
    #1;
    checks++;
    if ({bus.CDI_PC_odr, bus.RS1_ready, bus.CDI_PD_uops1} !== {V_odrf1, 1'b1, 6'h22}) begin
      errors++;
      $display("FAIL hazard_switch: odr=%b rdy1=%b u1=%h, want 10 1 22", bus.CDI_PC_odr, bus.RS1_ready, bus.CDI_PD_uops1);
    end
    @(negedge clk);
    idle(V_unpip);
    #1;
    checks++;
    if ({bus.CDI_PC_odr, bus.CDI_PD_uops1} !== {V_odrf0, 6'h3F}) begin
      errors++;
      $display("FAIL hazard_after: odr=%b u1=%h, want 01 3f", bus.CDI_PC_odr, bus.CDI_PD_uops1);
    end
  endtask
  task automatic test_lone_blocked();
    do_reset();
    drive(1'b1, 6'h07, 5'd1, 1'b0, 6'h0, 5'd0, V_unpip, 1'b0);
    @(negedge clk);
    idle(V_unpip);
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (bus.CDI_PC_odr !== V_odrf0) begin
        errors++;
        $display("FAIL lone_hold[%0d]: odr=%b want 01", c, bus.CDI_PC_odr);
      end
      @(negedge clk);
    end
    bus.CDO_PC_selrsv = V_pip0;
    #1;
    checks++;
    if (bus.RS0_ready !== 1'b1) begin
      errors++;
      $display("FAIL lone_accept_ready: rdy0=%b want 1", bus.RS0_ready);
    end
    @(negedge clk);
    idle(V_unpip);
    #1;
    checks++;
    if ({bus.CDI_PC_odr, bus.CDI_PD_uops0} !== {V_odrnone, 6'h3F}) begin
      errors++;
      $display("FAIL lone_drained: odr=%b u0=%h, want 00 3f", bus.CDI_PC_odr, bus.CDI_PD_uops0);
    end
    drive(1'b1, 6'h08, 5'd2, 1'b1, 6'h09, 5'd3, V_unpip, 1'b0);
    @(negedge clk);
    idle(V_unpip);
    #1;
    checks++;
    if (bus.CDI_PC_odr !== V_odrf1) begin
      errors++;
      $display("FAIL lone_ptr_after_accept: odr=%b want 10", bus.CDI_PC_odr);
    end
    do_reset();
    drive(1'b1, 6'h07, 5'd1, 1'b0, 6'h0, 5'd0, V_unpip, 1'b0);
    @(negedge clk);
    idle(V_unpip);
    repeat (10) @(negedge clk);
    drive(1'b0, 6'h0, 5'd0, 1'b1, 6'h0E, 5'd6, V_unpip, 1'b0);
    @(negedge clk);
    idle(V_unpip);
    #1;
    checks++;
    if (bus.CDI_PC_odr !== V_odrf0) begin
      errors++;
      $display("FAIL lone_sat_first: odr=%b want 01", bus.CDI_PC_odr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.CDI_PC_odr !== V_odrf1) begin
      errors++;
      $display("FAIL lone_sat_switch: odr=%b want 10 (retry saturated)", bus.CDI_PC_odr);
    end
  endtask
  task automatic test_clear_accept();
    do_reset();
    drive(1'b1, 6'h0A, 5'd1, 1'b1, 6'h0B, 5'd2, V_unpip, 1'b0);
    @(negedge clk);
    drive(1'b0, 6'h0, 5'd0, 1'b1, 6'h0C, 5'd3, V_pip0, 1'b1);
    #1;
    checks++;
    if ({bus.RS0_ready, bus.RS1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL clear_ready: rdy=%b%b want 00", bus.RS0_ready, bus.RS1_ready);
    end
    @(negedge clk);
    idle(V_unpip);
    #1;
    checks++;
    if ({bus.CDI_PC_odr, bus.CDI_PD_uops0, bus.CDI_PD_uops1, bus.RS1_ready} !== {V_odrnone, 6'h3F, 6'h3F, 1'b1}) begin
      errors++;
      $display("FAIL clear_empty: odr=%b u0=%h u1=%h rdy1=%b, want 00 3f 3f 1",
               bus.CDI_PC_odr, bus.CDI_PD_uops0, bus.CDI_PD_uops1, bus.RS1_ready);
    end
  endtask
  task automatic test_random();
    logic [1:0] m_v;
    uops_t m_u[2];
    rd_t m_r[2];
    logic m_ptr, v0, v1, clr, a0, a1, e0, e1, both;
    int m_ref;
    uops_t u0, u1;
    rd_t r0, r1;
    selrsv_t sel;
    odr_t eo;
    do_reset();
    m_v = 2'b00; m_ptr = 1'b0; m_ref = 0;
    for (int n = 0; n < 600; n++) begin
      eo = (m_v == 2'b00) ? V_odrnone : (m_v == 2'b11) ? (m_ptr ? V_odrf1 : V_odrf0) : (m_v[0] ? V_odrf0 : V_odrf1);
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      u0 = 6'($urandom); u1 = 6'($urandom); r0 = 5'($urandom); r1 = 5'($urandom);
      clr = $urandom_range(0, 39) == 0;
      sel = ($urandom_range(0, 2) != 0) ? ((eo == V_odrf0) ? V_pip0 : (eo == V_odrf1) ? V_pip1 : V_unpip) : 2'($urandom);
      drive(v0, u0, r0, v1, u1, r1, sel, clr);
      a0 = (sel == V_pip0) && m_v[0];
      a1 = (sel == V_pip1) && m_v[1];
      e0 = !clr && (!m_v[0] || a0);
      e1 = !clr && (!m_v[1] || a1);
      #1;
      checks++;
      if ({bus.CDI_PC_odr, bus.CDI_PD_uops0, bus.CDI_PD_uops1, bus.CDI_PD_rd0, bus.CDI_PD_rd1, bus.RS0_ready, bus.RS1_ready}
          !== {eo, m_v[0] ? m_u[0] : 6'h3F, m_v[1] ? m_u[1] : 6'h3F, m_v[0] ? m_r[0] : 5'd0, m_v[1] ? m_r[1] : 5'd0, e0, e1}) begin
        errors++;
        $display("FAIL random[%0d]: odr=%b u=%h/%h rd=%0d/%0d rdy=%b%b, want odr=%b u=%h/%h rd=%0d/%0d rdy=%b%b", n,
                 bus.CDI_PC_odr, bus.CDI_PD_uops0, bus.CDI_PD_uops1, bus.CDI_PD_rd0, bus.CDI_PD_rd1, bus.RS0_ready, bus.RS1_ready,
                 eo, m_v[0] ? m_u[0] : 6'h3F, m_v[1] ? m_u[1] : 6'h3F, m_v[0] ? m_r[0] : 5'd0, m_v[1] ? m_r[1] : 5'd0, e0, e1);
      end
      @(negedge clk);
      both = &m_v;
      if (clr) begin
        m_v = 2'b00; m_ptr = 1'b0; m_ref = 0;
      end else begin
        if (v0 && e0) begin m_v[0] = 1'b1; m_u[0] = u0; m_r[0] = r0; end
        else if (a0) m_v[0] = 1'b0;
        if (v1 && e1) begin m_v[1] = 1'b1; m_u[1] = u1; m_r[1] = r1; end
        else if (a1) m_v[1] = 1'b0;
        if (a0 || a1) begin
          m_ptr = a0; m_ref = 0;
        end else if (eo != V_odrnone) begin
          m_ref++;
          if (both && m_ref >= MAX_RETRY) begin m_ptr = !m_ptr; m_ref = 0; end
          else if (!both && m_ref > MAX_RETRY - 1) m_ref = MAX_RETRY - 1;
        end else m_ref = 0;
      end
    end
  endtask
`ifdef SCB_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    drive(1'b1, 6'h01, 5'd1, 1'b1, 6'h02, 5'd2, V_unpip, 1'b0);
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 6'h01, 5'd1, 1'b1, 6'h02, 5'd2, (c < 5) ? V_pip0 : (c < 8) ? V_pip1 : V_unpip, 1'b0);
      @(negedge clk);
    end
    #1;
    checks++;
    if ({perf_acc0, perf_acc1, perf_stall} !== {16'd5, 16'd3, 16'd4}) begin
      errors++;
      $display("FAIL perf_counts: acc0=%0d acc1=%0d stall=%0d, want 5 3 4", perf_acc0, perf_acc1, perf_stall);
    end
    idle(V_unpip);
    repeat (70000) @(negedge clk);
    drive(1'b0, 6'h0, 5'd0, 1'b0, 6'h0, 5'd0, V_unpip, 1'b1);
    @(negedge clk);
    idle(V_unpip);
    #1;
    checks++;
    if ({perf_acc0, perf_acc1, perf_stall} !== {16'd5, 16'd3, 16'hFFFF}) begin
      errors++;
      $display("FAIL perf_saturate: acc0=%0d acc1=%0d stall=%h, want 5 3 ffff", perf_acc0, perf_acc1, perf_stall);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_alternation();
    test_hazard_timeout();
    test_lone_blocked();
    test_clear_accept();
    test_random();
`ifdef SCB_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scb_issue_arbiter.md
Name: scb_issue_arbiter

Overview:
- Sits between the two issue queues (pipe0 = EX, pipe1 = MUL) and the pip3 scoreboard.
- Buffers one uop per pipe in a holding slot and drives the scoreboard's uops/rd/order inputs.
- Reads the scoreboard's accepted-pipe select each cycle, so only one slot is offered per cycle.
- Arbitrates fairly, with round-robin plus retry-timeout, so a hazard-blocked pipe cannot starve the other.

Parameters:
- W_PA_REG, 5, destination register address width
- W_PD_UOPS, 6, uop code width
- W_PC_SEL_RSV, 2, scoreboard accept-select width
- W_PC_SEL_ODR, 2, order-select width
- unused_op, all ones of W_PD_UOPS, bubble uop code
- V_unpip / V_pip0 / V_pip1, 2'b00 / 2'b01 / 2'b10, accept-select codes
- V_odrnone / V_odrf0 / V_odrf1, 2'b00 / 2'b01 / 2'b10, order codes
- MAX_RETRY, 4, consecutive refused offers before switching pipe (>=1)
- W_RETRY, 3, retry counter width (must hold MAX_RETRY)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset asynchronous and active-high
- RS0_valid  in  1  pipe0 queue has a uop
- RS0_uops  in  W_PD_UOPS  pipe0 uop
- RS0_rd  in  W_PA_REG  pipe0 destination
- RS0_ready  out  1  pipe0 uop taken this edge
- RS1_valid / RS1_uops / RS1_rd / RS1_ready  as above, pipe1
- CDI_PD_uops0 / CDI_PD_uops1  out  W_PD_UOPS  slot contents to the scoreboard
- CDI_PD_rd0 / CDI_PD_rd1  out  W_PA_REG  slot destinations
- CDI_PC_odr  out  W_PC_SEL_ODR  which slot is offered
- CDO_PC_selrsv  in  W_PC_SEL_RSV  scoreboard accept (combinational from odr)
- CFI_PC_clear  in  1  pipeline flush

Behaviour:
- **State:** slot_v[1:0], slot_uops, slot_rd per pipe; ptr (preferred pipe, 0/1); retry counter.
- **Reset (async):**
  - slot_v=0, ptr=0, retry=0.
  - Outputs: CDI_PD_uops0/1=unused_op, CDI_PD_rd0/1=0, CDI_PC_odr=V_odrnone, RS0/1_ready=0.
- **Slot outputs:**
  - CDI_PD_uopsk = slot_uops_k if slot_v[k], else unused_op.
  - CDI_PD_rdk = slot_rd_k if slot_v[k], else 0.
  - Both are registered-only paths.
- **Order (combinational from regs):**
  - Both slots empty -> V_odrnone.
  - Exactly one slot full -> that slot.
  - Both full -> the slot selected by ptr.
- **Accept:** acc0 = (selrsv==V_pip0) && slot_v[0]; acc1 likewise with V_pip1. Any other selrsv value means no accept.
- **Ready:** RSk_ready = !CFI_PC_clear && (!slot_v[k] || acck). Combinational through the scoreboard.
- **Load:** on a clock edge with RSk_valid && RSk_ready, slot k <= RS uop, slot_v[k] <= 1. Simultaneous accept + load = back-to-back, no bubble.
- **Drain:** acck && !load -> slot_v[k] <= 0.
- **Pointer:**
  - On acck: ptr <= !k, retry <= 0.
  - Offered slot refused (odr != none, no accept):
    - retry increments.
    - If retry == MAX_RETRY-1 and the other slot is full: ptr flips and retry <= 0.
    - If the other slot is empty: retry saturates at MAX_RETRY-1.
  - odr == none: retry <= 0.
- **Clear:**
  - CFI_PC_clear has priority over load/accept: slot_v <= 0, ptr <= 0, retry <= 0.
  - Ready is low during clear.
  - Clear asserted while a slot is being accepted still empties the slot; the scoreboard flushes its cell in the same cycle.
- **Invariants:**
  - At most one slot drains per cycle.
  - A uop never drops or duplicates except on clear.
  - Latency queue->offer is 1 cycle.

Optional Feature:
- Macro: SCB_ARB_PERF_EN.
- Defined:
  - Adds outputs PERF_acc0, PERF_acc1 and PERF_stall, each 16 bits, saturating.
  - PERF_acc0/1 count accepts per pipe.
  - PERF_stall counts cycles with odr != none and no accept.
  - Reset to 0 on rst only, not on clear.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include `scb_defs`: unused_op, V_unpip/V_pip0/V_pip1, V_odrnone/V_odrf0/V_odrf1, widths W_PA_REG, W_PD_UOPS, W_PC_SEL_*. These are shared with the pip3 scoreboard.
- One natural sub-module, scb_issue_slot: a one-entry holding register with valid/load/drain/clear, instantiated twice.
- Arbitration and retry logic stay in the top.

Test Plan:
1. Reset mid-traffic: assert rst with both slots full -> same cycle odr=00, uops0/1=6'h3F, ready=0; after release, RS0 uop 6'h05 rd 3 is offered next cycle with odr=01.
2. Alternation: both queues continuously valid, scoreboard always accepts -> offers alternate 01,10,01,10…; RS0_ready/RS1_ready high every other cycle; no bubbles.
3. Hazard timeout, MAX_RETRY=4: pipe0 refused (selrsv=00) while pipe1 is full -> odr=01 for 4 cycles, then 10; pipe1 is accepted on its first offer.
4. Lone blocked slot: only pipe0 full, refused for 10 cycles -> odr stays 01; retry saturates at 3; accept on cycle 11 -> slot empties and ptr=1.
5. Clear with accept: CFI_PC_clear=1 while selrsv=01 and RS1_valid=1 -> next cycle both slots empty, RS1 uop not loaded, odr=00.
6. SCB_ARB_PERF_EN: 5 accepts on pipe0, 3 on pipe1, 4 refused cycles -> counters 5/3/4; 70000 refusals -> PERF_stall=16'hFFFF.
